// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory watchdog.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic [4:0] ID_EX_RD_i,
  input  logic       ID_EX_MemRead_i,
  input  logic       branch_taken_i,
  input  logic       mem_req_i,
  input  logic       mem_ack_i,
  output logic       PcWrite_o,
  output logic       IF_ID_Write_o,
  output logic       IF_ID_Flush_o,
  output logic       ID_EX_NoOp_o,
  output logic       Freeze_o,
  output logic       mem_err_o,
  output logic [1:0] state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_o,
  output logic [31:0] perf_mem_o,
  output logic [31:0] perf_flush_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t           state, stateNxt;
  logic [CNT_W-1:0] waitCnt, waitCntNxt;
  logic             memErr, memErrNxt;
  logic             inRun, inWait, inErr;
  logic             freeze, hazard;
  logic             rs1Hit, rs2Hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= RUN;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitCntNxt;
      memErr  <= memErrNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    waitCntNxt = waitCnt;
    memErrNxt  = memErr;
    unique case (state)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          stateNxt   = MEM_WAIT;
          waitCntNxt = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          stateNxt = RUN;
        end else begin
          waitCntNxt = waitCnt + CNT_W'(1);
          if (TIMEOUT != 0 && waitCnt == LAST) begin
            stateNxt  = ERR;
            memErrNxt = 1'b1;
          end
        end
      end
      default: begin
        stateNxt  = ERR;
        memErrNxt = 1'b1;
      end
    endcase
  end

  assign inRun  = state == RUN;
  assign inWait = state == MEM_WAIT;
  assign inErr  = !inRun && !inWait;

  // the ack cycle itself advances the pipeline
  assign freeze = (inRun && mem_req_i && !mem_ack_i)
                || (inWait && !mem_ack_i)
                || inErr;

  assign rs1Hit = rs1_addr_i == ID_EX_RD_i;
  assign rs2Hit = rs2_addr_i == ID_EX_RD_i;
  assign hazard = ID_EX_MemRead_i
                && (ID_EX_RD_i != 5'd0)
                && (rs1Hit || rs2Hit);

  always_comb begin
    PcWrite_o     = 1'b0;
    IF_ID_Write_o = 1'b0;
    IF_ID_Flush_o = 1'b0;
    ID_EX_NoOp_o  = 1'b0;
    Freeze_o      = 1'b0;
    priority case (1'b1)
      !rst_i: ;
      freeze: Freeze_o = 1'b1;
      hazard: ID_EX_NoOp_o = 1'b1;
      default: begin
        PcWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_Flush_o = branch_taken_i;
      end
    endcase
  end

  assign state_o   = state;
  assign mem_err_o = memErr;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perfLu, perfMem, perfFlush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perfLu    <= '0;
      perfMem   <= '0;
      perfFlush <= '0;
    end else begin
      if (ID_EX_NoOp_o && perfLu != '1)
        perfLu <= perfLu + 32'd1;
      if (Freeze_o && perfMem != '1)
        perfMem <= perfMem + 32'd1;
      if (IF_ID_Flush_o && perfFlush != '1)
        perfFlush <= perfFlush + 32'd1;
    end
  end

  assign perf_lu_o    = perfLu;
  assign perf_mem_o   = perfMem;
  assign perf_flush_o = perfFlush;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges three stall sources into one set of per-stage controls for PC, IF/ID, ID/EX and the back-end registers:
  - ID-stage load-use hazards.
  - Multi-cycle data-memory accesses (req/ack handshake from MEM stage).
  - Taken branches resolved in ID.
- Owns a small FSM with a memory watchdog. Sits beside the PC/IF_ID/ID_EX register instances in the CPU top.

Parameters:
- TIMEOUT, 64, max MEM_WAIT cycles before declaring a memory error; 0 disables the watchdog.
- CNT_W, 7, width of the internal wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- rs1_addr_i  in  5  IF/ID instruction rs1
- rs2_addr_i  in  5  IF/ID instruction rs2
- ID_EX_RD_i  in  5  destination reg of instruction in EX
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- branch_taken_i  in  1  ID resolved a taken branch/jump
- mem_req_i  in  1  MEM-stage instruction accesses data memory; held until ack
- mem_ack_i  in  1  data memory completes access (1-cycle pulse)
- PcWrite_o  out  1  PC register enable
- IF_ID_Write_o  out  1  IF/ID register enable
- IF_ID_Flush_o  out  1  IF/ID clear to NOP
- ID_EX_NoOp_o  out  1  insert bubble into ID/EX
- Freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB (global stall)
- mem_err_o  out  1  sticky watchdog error
- state_o  out  2  FSM state for debug

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=RUN(2'd0), wait_cnt=0, mem_err_o=0.
  - While reset is asserted, every control output is forced to 0: PcWrite_o=0, IF_ID_Write_o=0, Flush/NoOp/Freeze=0.
- FSM states: RUN=0, MEM_WAIT=1, ERR=2 (3 unused, decodes as ERR).
- RUN:
  - mem_req_i & !mem_ack_i -> MEM_WAIT, wait_cnt<=0.
  - mem_req_i & mem_ack_i -> stay RUN (single-cycle access, no stall).
- MEM_WAIT:
  - mem_ack_i -> RUN.
  - Otherwise wait_cnt<=wait_cnt+1.
  - If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with no ack -> ERR, mem_err_o<=1.
  - mem_req_i dropping without ack is a protocol violation; stay in MEM_WAIT.
- ERR: absorbing until reset; mem_err_o stays 1.
- freeze (combinational) = (RUN & mem_req_i & !mem_ack_i) | (MEM_WAIT & !mem_ack_i) | ERR.
- hazard (combinational) = ID_EX_MemRead_i & (ID_EX_RD_i!=0) & (rs1_addr_i==ID_EX_RD_i | rs2_addr_i==ID_EX_RD_i). x0 never stalls.
- Output priority, highest first:
  - freeze: Freeze_o=1, PcWrite_o=0, IF_ID_Write_o=0, NoOp=0, Flush=0.
  - hazard: PcWrite_o=0, IF_ID_Write_o=0, ID_EX_NoOp_o=1, Flush=0. The branch is ignored because its operands are unresolved.
  - branch_taken_i: PcWrite_o=1, IF_ID_Write_o=1, IF_ID_Flush_o=1.
  - otherwise: PcWrite_o=1, IF_ID_Write_o=1, all others 0.
- Latency and freeze/branch interaction:
  - A load-use stall lasts exactly one cycle, because the bubble clears ID_EX_MemRead.
  - The ack cycle itself is not frozen; the pipeline advances in that cycle.
  - A branch seen while frozen is held in ID by the freeze and applied on the first unfrozen cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_lu_o[31:0]: counts cycles where hazard drives the outputs.
  - perf_mem_o[31:0]: counts cycles with Freeze_o=1.
  - perf_flush_o[31:0]: counts cycles with IF_ID_Flush_o=1.
- Counter rules: reset to 0 asynchronously, saturate at 32'hFFFF_FFFF, do not count while rst_i=0.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Load-use, positive: MemRead=1, RD=5, rs1=5.
  - Expect exactly 1 cycle of PcWrite=0, IF_ID_Write=0, NoOp=1, then the bubble clears MemRead and outputs return to normal.
- Load-use, x0: RD=0, rs1=0, MemRead=1.
  - Expect no stall: PcWrite=1, NoOp=0.
- Memory wait: mem_req=1 at cycle 0, mem_ack pulse at cycle 3.
  - Freeze_o=1 in cycles 0-2, 0 in cycle 3.
  - state_o = 0,1,1,1, then 0 in cycle 4.
- Watchdog: TIMEOUT=8, mem_req held, no ack.
  - state_o=2 and mem_err_o=1 from cycle 9 onward; Freeze_o stays 1.
  - Pulsing ack afterwards has no effect.
- Priority: hazard + branch_taken together.
  - Expect NoOp=1, Flush=0.
  - Branch held during a 2-cycle memory freeze gives Flush=1 on the ack cycle.
- Reset mid-MEM_WAIT: drive rst_i=0 asynchronously.
  - Immediately state_o=0, mem_err_o=0, all outputs 0.
  - With PIPE_PERF_CNT_EN defined, the perf counters also read 0.
